// File: rtl/add_pipe_stage_if.sv
// Operand/result bus for add_pipe_stage: add_in side (a, b, in_valid/in_ready)
// and add_out side (sum, cout, out_valid/out_ready).
interface add_pipe_stage_if #(
    parameter int unsigned ADD_WIDTH = 4
) ();
    logic [ADD_WIDTH-1:0] a;
    logic [ADD_WIDTH-1:0] b;
    logic                 in_valid;
    logic                 in_ready;
    logic [ADD_WIDTH-1:0] sum;
    logic                 cout;
    logic                 out_valid;
    logic                 out_ready;

    // master: operand initiator that also sinks results
    modport master (
        output a, b, in_valid, out_ready,
        input  in_ready, sum, cout, out_valid
    );

    modport slave (
        input  a, b, in_valid, out_ready,
        output in_ready, sum, cout, out_valid
    );
endinterface

// File: rtl/add_pipe_stage.sv
// Two-stage valid/ready pipelined adder with saturating delivery/carry statistics.
// Optional feature macro: ADD_PIPE_SAT_EN (saturating sum on carry).
module add_pipe_stage #(
    parameter int unsigned ADD_WIDTH = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    add_pipe_stage_if.slave      add_io,
    input  logic                 clr_stats,
    output logic [CNT_WIDTH-1:0] txn_count,
    output logic [CNT_WIDTH-1:0] carry_count
);
    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    logic [ADD_WIDTH-1:0] r_s1_a;
    logic [ADD_WIDTH-1:0] r_s1_b;
    logic                 r_s1_v;
    logic [ADD_WIDTH-1:0] r_s2_sum;
    logic                 r_s2_cout;
    logic                 r_s2_v;
    logic [CNT_WIDTH-1:0] r_txn;
    logic [CNT_WIDTH-1:0] r_carry;

    logic                 w_s2_adv;
    logic                 w_s1_adv;
    logic                 w_accept;
    logic                 w_deliver;
    logic [ADD_WIDTH:0]   w_full;
    logic [ADD_WIDTH-1:0] w_s2_sum;

    assign w_s2_adv  = !r_s2_v || add_io.out_ready;
    assign w_s1_adv  = !r_s1_v || w_s2_adv;
    assign w_accept  = add_io.in_valid && w_s1_adv;
    assign w_deliver = r_s2_v && add_io.out_ready;

    assign w_full = {1'b0, r_s1_a} + {1'b0, r_s1_b};

`ifdef ADD_PIPE_SAT_EN
    // Clamp on overflow; cout still reports the true carry.
    assign w_s2_sum = w_full[ADD_WIDTH] ? {ADD_WIDTH{1'b1}} : w_full[ADD_WIDTH-1:0];
`else
    assign w_s2_sum = w_full[ADD_WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_a    <= '0;
            r_s1_b    <= '0;
            r_s1_v    <= 1'b0;
            r_s2_sum  <= '0;
            r_s2_cout <= 1'b0;
            r_s2_v    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_a <= add_io.a;
                r_s1_b <= add_io.b;
                r_s1_v <= 1'b1;
            end else if (w_s1_adv) begin
                r_s1_v <= 1'b0;
            end
            if (w_s2_adv) begin
                r_s2_v <= r_s1_v;
                // Result registers keep their last value while the pipe is empty.
                if (r_s1_v) begin
                    r_s2_sum  <= w_s2_sum;
                    r_s2_cout <= w_full[ADD_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            r_txn   <= '0;
            r_carry <= '0;
        end else if (w_deliver) begin
            if (r_txn != CntMax) begin
                r_txn <= r_txn + 1'b1;
            end
            if (r_s2_cout && (r_carry != CntMax)) begin
                r_carry <= r_carry + 1'b1;
            end
        end
    end

    assign add_io.in_ready  = w_s1_adv;
    assign add_io.sum       = r_s2_sum;
    assign add_io.cout      = r_s2_cout;
    assign add_io.out_valid = r_s2_v;
    assign txn_count        = r_txn;
    assign carry_count      = r_carry;
endmodule
